// File: rtl/datamem_mmio_pkg.sv
// Shared address map, STATUS bit layout and address decoder for datamem_mmio.
// Combinational helpers only; no state, no backpressure.
package datamem_mmio_pkg;

    localparam logic [31:0] ADDR_CYCLE  = 32'h0000_0400;
    localparam logic [31:0] ADDR_CMP    = 32'h0000_0404;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0408;
    localparam logic [31:0] ADDR_TXQ    = 32'h0000_040C;

    localparam int ST_TIMER   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_CMP,
        SEL_STATUS,
        SEL_TXQ
    } sel_e;

    // Byte offset bits are dropped so every access resolves to a whole word.
    function automatic sel_e decode(input logic [31:0] addr, input int ram_words);
        logic [31:0] wa;
        sel_e        sel;
        wa  = {addr[31:2], 2'b00};
        sel = SEL_NONE;
        if (wa < 32'(4 * ram_words)) sel = SEL_RAM;
        else if (wa == ADDR_CYCLE)   sel = SEL_CYCLE;
        else if (wa == ADDR_CMP)     sel = SEL_CMP;
        else if (wa == ADDR_STATUS)  sel = SEL_STATUS;
        else if (wa == ADDR_TXQ)     sel = SEL_TXQ;
        return sel;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Circular FIFO with combinational head; push/pop take effect at the clock edge.
// Push is refused when full unless a pop frees the slot in the same cycle.
module mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [W-1:0]             head_dat_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o     = (cnt_q == (PW + 1)'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers are PW bits wide, so wrap modulo DEPTH comes for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/datamem_mmio.sv
// Core data RAM plus CYCLE/CMP timer, STATUS and TXQ output FIFO on one word bus.
// Reads are combinational (zero latency); writes commit at the edge; TXQ drops when full.
module datamem_mmio
    import datamem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_wr,
    output logic [31:0] data_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        irq
);
    localparam int IDX_W = $clog2(RAM_WORDS);

    logic [31:0]      ram [RAM_WORDS];
    logic [IDX_W-1:0] ram_idx;
    sel_e             sel;

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cmp_q, cmp_d;
    logic        timer_q, timer_d;
    logic        ovf_q, ovf_d;

    logic                        fifo_full, fifo_empty, fifo_pop, txq_wr;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic [31:0]                 status_w;
    logic                        timer_set, timer_clr, ovf_set, ovf_clr;

    assign sel     = decode(data_addr, RAM_WORDS);
    assign ram_idx = data_addr[IDX_W+1:2];

    assign txq_wr   = data_wr && (sel == SEL_TXQ);
    assign fifo_pop = out_valid && out_ready;

    mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk        (clk),
        .nrst       (nrst),
        .push_i     (txq_wr),
        .push_dat_i (data_wdata),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt),
        .head_dat_o (out_data)
    );

    assign out_valid = !fifo_empty;
    assign irq       = timer_q;

    assign timer_set = (cycle_q == cmp_q) && (cmp_q != '0);
    assign timer_clr = data_wr && ((sel == SEL_CMP) ||
                                   ((sel == SEL_STATUS) && data_wdata[ST_TIMER]));
    assign ovf_set   = txq_wr && fifo_full && !fifo_pop;
    assign ovf_clr   = data_wr && (sel == SEL_STATUS) && data_wdata[ST_OVF];

    // Set is applied after clear so a coincident match wins.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        cmp_d   = cmp_q;
        timer_d = timer_q;
        ovf_d   = ovf_q;
        if (data_wr && (sel == SEL_CMP)) cmp_d = data_wdata;
        if (timer_clr) timer_d = 1'b0;
        if (timer_set) timer_d = 1'b1;
        if (ovf_clr)   ovf_d   = 1'b0;
        if (ovf_set)   ovf_d   = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cycle_q <= '0;
            cmp_q   <= '0;
            timer_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_wr && (sel == SEL_RAM)) ram[ram_idx] <= data_wdata;
    end

    always_comb begin
        status_w                            = '0;
        status_w[ST_TIMER]                  = timer_q;
        status_w[ST_FULL]                   = fifo_full;
        status_w[ST_EMPTY]                  = fifo_empty;
        status_w[ST_OVF]                    = ovf_q;
        status_w[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_cnt);
    end

    always_comb begin
        data_rdata = '0;
        case (sel)
            SEL_RAM:    data_rdata = ram[ram_idx];
            SEL_CYCLE:  data_rdata = cycle_q;
            SEL_CMP:    data_rdata = cmp_q;
            SEL_STATUS: data_rdata = status_w;
            default:    data_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_datamem_mmio.sv
// Bench for datamem_mmio: directed bus accesses with expected read data and
// expected FIFO output words queued at issue time and checked by monitors.
module tb_datamem_mmio;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_wr = 1'b0;
    logic [31:0] data_rdata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [31:0] fifo_exp_q[$];
    logic        rd_chk = 1'b0;
    logic [31:0] mcyc;

    always #5 clk = ~clk;

    datamem_mmio #(.RAM_WORDS(256), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_wr    (data_wr),
        .data_rdata (data_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    // Reference cycle counter: cycles elapsed since reset release.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) mcyc <= '0;
        else       mcyc <= mcyc + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_chk) begin
            if (rd_exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL read_scoreboard: read sampled with no expectation queued");
            end else begin
                check(rd_name_q.pop_front(), data_rdata, rd_exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            if (fifo_exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL fifo_extra_word: got 0x%08h, expected no word", out_data);
            end else begin
                check("fifo_out", out_data, fifo_exp_q.pop_front());
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [31:0] e, input string n);
        data_addr = a;
        data_wr   = 1'b0;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(n);
        rd_chk = 1'b1;
        @(posedge clk);
        #1;
        rd_chk = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        data_addr  = a;
        data_wdata = d;
        data_wr    = 1'b1;
        @(posedge clk);
        #1;
        data_wr = 1'b0;
    endtask

    task automatic do_write_chk(input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] pre, input string n);
        rd_exp_q.push_back(pre);
        rd_name_q.push_back(n);
        rd_chk     = 1'b1;
        data_addr  = a;
        data_wdata = d;
        data_wr    = 1'b1;
        @(posedge clk);
        #1;
        data_wr = 1'b0;
        rd_chk  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(posedge clk);
        #1;
        // Reset state
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        do_read(32'h408, 32'h0000_0004, "rst_status");
        do_read(32'h400, 32'h0, "rst_cycle");
        do_read(32'h404, 32'h0, "rst_cmp");

        // Timer: release, CMP=20 written while CYCLE==5
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        do_write(32'h404, 32'd20);
        do_read(32'h404, 32'd20, "cmp_readback");
        repeat (13) @(posedge clk);
        #1;
        do_read(32'h408, 32'h0000_0004, "status_before_match");
        check("irq_set", {31'b0, irq}, 32'd1);
        do_read(32'h400, 32'd21, "cycle_after_match");
        do_read(32'h408, 32'h0000_0005, "status_timer");
        do_write(32'h408, 32'h1);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        do_read(32'h408, 32'h0000_0004, "status_timer_cleared");

        // RAM
        do_write(32'h010, 32'hDEAD_BEEF);
        do_read(32'h010, 32'hDEAD_BEEF, "ram_0x010");
        do_read(32'h013, 32'hDEAD_BEEF, "ram_0x013");
        do_write(32'h020, 32'hA5A5_A5A5);
        do_write_chk(32'h020, 32'h5A5A_5A5A, 32'hA5A5_A5A5, "ram_pre_write");
        do_read(32'h020, 32'h5A5A_5A5A, "ram_post_write");
        do_write(32'h3FC, 32'h0BAD_F00D);
        do_read(32'h3FC, 32'h0BAD_F00D, "ram_top_word");
        do_read(32'h40C, 32'h0, "txq_reads_zero");

        // FIFO fill, overflow, overflow clear
        for (int i = 1; i <= 8; i++) begin
            do_write(32'h40C, 32'(i));
            fifo_exp_q.push_back(32'(i));
        end
        do_read(32'h408, 32'h0000_0082, "status_full");
        do_write(32'h40C, 32'd9);
        do_read(32'h408, 32'h0000_008A, "status_overflow");
        check("head_hold", out_data, 32'd1);
        do_write(32'h408, 32'h8);
        do_read(32'h408, 32'h0000_0082, "status_ovf_cleared");

        // Push into full FIFO with a same-cycle pop
        out_ready = 1'b1;
        fifo_exp_q.push_back(32'h55);
        do_write(32'h40C, 32'h55);
        out_ready = 1'b0;
        do_read(32'h408, 32'h0000_0082, "status_push_pop_full");
        check("head_after_pop", out_data, 32'd2);

        // Drain
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        check("drain_done", {31'b0, out_valid}, 32'd0);
        check("drain_leftover", 32'(fifo_exp_q.size()), 32'd0);
        do_read(32'h408, 32'h0000_0004, "status_drained");

        // Reset mid-drain
        for (int i = 0; i < 4; i++) begin
            do_write(32'h40C, 32'hA1 + 32'(i));
            fifo_exp_q.push_back(32'hA1 + 32'(i));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        nrst = 1'b0;
        out_ready = 1'b0;
        fifo_exp_q.delete();
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_irq", {31'b0, irq}, 32'd0);
        do_read(32'h400, 32'h0, "mid_rst_cycle");
        do_read(32'h408, 32'h0000_0004, "mid_rst_status");
        nrst = 1'b1;
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        do_read(32'h010, 32'hDEAD_BEEF, "ram_kept_over_reset");

        // Unmapped and read-only
        do_read(32'h500, 32'h0, "unmapped_0x500");
        do_read(32'h0000_1404, 32'h0, "unmapped_alias");
        do_write(32'h500, 32'h1234_5678);
        do_read(32'h500, 32'h0, "unmapped_write_ignored");
        do_write(32'h400, 32'hFFFF_FFF0);
        do_read(32'h400, mcyc, "cycle_write_ignored");

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
